// File: rtl/apb_periph_router.sv
// APB one-to-many router: decodes the upstream address against per-slave inclusive
// windows and runs a single SETUP/ACCESS transfer on the selected slave.
module apb_periph_router #(
    parameter int NB_SLAVES      = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,

    input  logic [APB_ADDR_WIDTH-1:0]           s_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           s_pwdata_i,
    input  logic                                s_pwrite_i,
    input  logic                                s_psel_i,
    input  logic                                s_penable_i,
    output logic [APB_DATA_WIDTH-1:0]           s_prdata_o,
    output logic                                s_pready_o,
    output logic                                s_pslverr_o,

    output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
    output logic                                m_pwrite_o,
    output logic                                m_penable_o,
    output logic [NB_SLAVES-1:0]                m_psel_o,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLAVES-1:0]                m_pready_i,
    input  logic [NB_SLAVES-1:0]                m_pslverr_i,

    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,

    output logic                                timeout_o
);

    localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic                      tmo_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;

    logic                      latch;
    logic                      capture;
    logic                      abort;

    // Descending scan so the lowest matching slave index is the one that sticks.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = NB_SLAVES - 1; k >= 0; k--) begin
            if (s_paddr_i >= start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                s_paddr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = m_pready_i[k];
                sel_err   = m_pslverr_i[k];
                sel_rdata = m_prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_psel_i && !s_penable_i) begin
                    latch   = 1'b1;
                    cnt_d   = '0;
                    state_d = dec_hit ? SETUP : RESP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready arriving on the final allowed cycle takes priority over the abort.
                if (sel_ready) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_VAL) begin
                    abort   = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d   = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q  <= s_paddr_i;
                wdata_q <= s_pwdata_i;
                write_q <= s_pwrite_i;
                idx_q   <= dec_idx;
                rdata_q <= '0;
                err_q   <= !dec_hit;
                tmo_q   <= 1'b0;
            end else if (capture) begin
                rdata_q <= sel_rdata;
                err_q   <= sel_err;
                tmo_q   <= 1'b0;
            end else if (abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tmo_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        m_psel_o = '0;
        if (state_q == SETUP || state_q == ACCESS) begin
            for (int k = 0; k < NB_SLAVES; k++) begin
                m_psel_o[k] = (idx_q == IDX_W'(k));
            end
        end
    end

    assign m_penable_o = (state_q == ACCESS);
    assign m_paddr_o   = addr_q;
    assign m_pwdata_o  = wdata_q;
    assign m_pwrite_o  = write_q;

    // Upstream response is only visible during the single RESP cycle.
    assign s_pready_o  = (state_q == RESP);
    assign s_pslverr_o = (state_q == RESP) && err_q;
    assign s_prdata_o  = (state_q == RESP) ? rdata_q : '0;
    assign timeout_o   = (state_q == RESP) && tmo_q;

endmodule

// File: doc/apb_periph_router.md
APB_PERIPH_ROUTER -- requirements
Module: apb_periph_router

Interface
REQ-001 Parameter NB_SLAVES, default 10, number of downstream APB slaves (1..32).
REQ-002 Parameter APB_ADDR_WIDTH, default 32, address width.
REQ-003 Parameter APB_DATA_WIDTH, default 32, data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before abort; 0 disables timeout.
REQ-005 clk_i  in  1  single clock; all logic rising-edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 s_paddr_i  in  APB_ADDR_WIDTH  upstream address.
REQ-008 s_pwdata_i  in  APB_DATA_WIDTH  upstream write data.
REQ-009 s_pwrite_i / s_psel_i / s_penable_i  in  1 each  upstream APB control.
REQ-010 s_prdata_o  out  APB_DATA_WIDTH  upstream read data.
REQ-011 s_pready_o / s_pslverr_o  out  1 each  upstream completion and error.
REQ-012 m_paddr_o / m_pwdata_o  out  APB_ADDR_WIDTH / APB_DATA_WIDTH  shared downstream address and write data.
REQ-013 m_pwrite_o / m_penable_o  out  1 each  shared downstream control.
REQ-014 m_psel_o  out  NB_SLAVES  one-hot downstream select.
REQ-015 m_prdata_i  in  NB_SLAVES x APB_DATA_WIDTH  per-slave read data.
REQ-016 m_pready_i / m_pslverr_i  in  NB_SLAVES each  per-slave ready and error.
REQ-017 start_addr_i / end_addr_i  in  NB_SLAVES x APB_ADDR_WIDTH  inclusive per-slave address window.
REQ-018 timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS, RESP; only one transfer in flight.
REQ-020 IDLE: on s_psel_i=1 and s_penable_i=0, latch address, wdata, pwrite and decoded index; otherwise stay.
REQ-021 Decode: hit if start_addr_i[k] <= addr <= end_addr_i[k], unsigned; multiple hits select lowest k.
REQ-022 IDLE hit -> SETUP; IDLE miss -> RESP with s_pslverr_o=1, s_prdata_o=0, no downstream select.
REQ-023 SETUP: m_psel_o[k]=1, m_penable_o=0, one cycle, -> ACCESS.
REQ-024 ACCESS: m_psel_o[k]=1, m_penable_o=1; on m_pready_i[k]=1, capture m_prdata_i[k] and m_pslverr_i[k], -> RESP.
REQ-025 ACCESS timeout: counter cleared on SETUP entry, incremented per ACCESS cycle without ready; when it equals TIMEOUT_CYCLES, drop select -> RESP with s_pslverr_o=1, s_prdata_o=0, timeout_o=1.
REQ-026 Ready on the same cycle the counter reaches TIMEOUT_CYCLES wins; no timeout.
REQ-027 RESP: s_pready_o=1 for exactly one cycle with captured data and error, then IDLE; s_pready_o=0 in every other state.
REQ-028 Zero-wait hit: upstream setup in cycle 0, s_pready_o=1 in cycle 3; miss: s_pready_o=1 in cycle 1.
REQ-029 m_paddr_o, m_pwdata_o, m_pwrite_o driven from latched values, stable from SETUP through ACCESS.
REQ-030 m_psel_o all zero and m_penable_o=0 in IDLE and RESP.
REQ-031 Upstream inputs changing after latch have no effect until next IDLE.

Reset
REQ-032 rst_ni low: state IDLE, m_psel_o=0, m_penable_o=0, s_pready_o=0, s_pslverr_o=0, s_prdata_o=0, timeout_o=0, counter 0, latched address/data 0, asynchronously.
REQ-033 Reset during SETUP/ACCESS drops downstream select immediately; no upstream response is issued for the aborted transfer.

Verification
REQ-034 Write 0x1A10_2004 (slave 1 window 0x1A10_2000-0x1A10_2FFF), zero-wait -> m_psel_o=0x002 cycles 1-2, s_pready_o=1 cycle 3, pslverr=0.
REQ-035 Read slave 3 with 2 wait states returning 0xDEAD_BEEF -> s_pready_o=1 cycle 5, s_prdata_o=0xDEAD_BEEF.
REQ-036 Read unmapped 0x0000_0010 -> no m_psel_o, s_pready_o=1 and s_pslverr_o=1 cycle 1, s_prdata_o=0.
REQ-037 TIMEOUT_CYCLES=4, slave never ready -> select dropped after 4 ACCESS cycles, timeout_o pulse, pslverr=1; slave ready on 4th cycle -> normal completion.
REQ-038 Overlapping windows slaves 2 and 5 -> m_psel_o=0x004.
REQ-039 rst_ni low mid-ACCESS -> all outputs 0 same cycle; next transfer after release completes normally.
